// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with instruction classification and stall/bubble counters
//
// Purpose: latches the fetched instruction, its PC+1 and its instruction number
// into the decode stage, and classifies the instruction into a 4-bit display type.
// It holds on load-use stalls and inserts bubbles on jump stalls and flushes.
// Saturating counters record hold cycles and inserted bubbles.
//
// Ports:
//   clk            pipeline clock
//   rst            synchronous active-low reset
//   id_wpcir       decode hazard hold request (1 = hold)
//   jmp_stall      with id_wpcir=1: load a bubble instead of holding
//   flush          taken branch/jump in ID: squash the fetched instruction
//   if_inst        fetched instruction
//   if_inst_pc     word address of if_inst
//   if_pc4         if_inst_pc + 1
//   id_inst        registered instruction (0 for a bubble)
//   id_pc4         registered PC+1
//   id_valid       1 = real instruction, 0 = bubble
//   ID_ins_number  registered low NUM_W bits of the instruction PC
//   ID_ins_type    registered display type code
//   stall_cnt      saturating count of hold cycles
//   bubble_cnt     saturating count of inserted bubbles

`ifndef INST_TYPE_NONE
`define INST_TYPE_NONE 4'd0
`define INST_TYPE_ADD  4'd1
`define INST_TYPE_SUB  4'd2
`define INST_TYPE_AND  4'd3
`define INST_TYPE_OR   4'd4
`define INST_TYPE_NOR  4'd5
`define INST_TYPE_SLT  4'd6
`define INST_TYPE_SLL  4'd7
`define INST_TYPE_SRL  4'd8
`define INST_TYPE_SRA  4'd9
`define INST_TYPE_LW   4'd10
`define INST_TYPE_SW   4'd11
`define INST_TYPE_BEQ  4'd12
`define INST_TYPE_BNE  4'd13
`define INST_TYPE_JMP  4'd14
`endif

`ifndef OP_ALUOp
`define OP_ALUOp 6'h00
`define OP_ADDI  6'h08
`define OP_ANDI  6'h0C
`define OP_ORI   6'h0D
`define OP_LW    6'h23
`define OP_SW    6'h2B
`define OP_BEQ   6'h04
`define OP_BNE   6'h05
`define OP_JMP   6'h02
`endif

`ifndef FUNCT_ADD
`define FUNCT_ADD 6'h20
`define FUNCT_SUB 6'h22
`define FUNCT_AND 6'h24
`define FUNCT_OR  6'h25
`define FUNCT_NOR 6'h27
`define FUNCT_SLT 6'h2A
`define FUNCT_SLL 6'h00
`define FUNCT_SRL 6'h02
`define FUNCT_SRA 6'h03
`endif

module if_id_reg #(
    parameter int DATA_W = 32,
    parameter int NUM_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_wpcir,
    input  logic              jmp_stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] if_inst,
    input  logic [DATA_W-1:0] if_inst_pc,
    input  logic [DATA_W-1:0] if_pc4,
    output logic [DATA_W-1:0] id_inst,
    output logic [DATA_W-1:0] id_pc4,
    output logic              id_valid,
    output logic [NUM_W-1:0]  ID_ins_number,
    output logic [3:0]        ID_ins_type,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Registered state
    logic [DATA_W-1:0] inst_q,   inst_d;
    logic [DATA_W-1:0] pc4_q,    pc4_d;
    logic              valid_q,  valid_d;
    logic [NUM_W-1:0]  num_q,    num_d;
    logic [3:0]        type_q,   type_d;
    logic [CNT_W-1:0]  stall_q,  stall_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    // Per-cycle action, already resolved by priority (stall > flush > load)
    logic do_hold;
    logic do_bubble;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] inst_type;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign opcode = if_inst[31:26];
    assign funct  = if_inst[5:0];

    // A held stall freezes everything, so a flush arriving alongside it is
    // dropped: the branch that raised it is itself still frozen in ID.
    assign do_hold   = id_wpcir & ~jmp_stall;
    assign do_bubble = (id_wpcir & jmp_stall) | (~id_wpcir & flush);

    // Instruction classification for the display type
    always_comb begin
        inst_type = `INST_TYPE_NONE;
        case (opcode)
            `OP_ALUOp: begin
                case (funct)
                    `FUNCT_ADD: inst_type = `INST_TYPE_ADD;
                    `FUNCT_SUB: inst_type = `INST_TYPE_SUB;
                    `FUNCT_AND: inst_type = `INST_TYPE_AND;
                    `FUNCT_OR:  inst_type = `INST_TYPE_OR;
                    `FUNCT_NOR: inst_type = `INST_TYPE_NOR;
                    `FUNCT_SLT: inst_type = `INST_TYPE_SLT;
                    `FUNCT_SLL: inst_type = `INST_TYPE_SLL;
                    `FUNCT_SRL: inst_type = `INST_TYPE_SRL;
                    `FUNCT_SRA: inst_type = `INST_TYPE_SRA;
                    default:    inst_type = `INST_TYPE_NONE;
                endcase
            end
            `OP_ADDI: inst_type = `INST_TYPE_ADD;
            `OP_ANDI: inst_type = `INST_TYPE_AND;
            `OP_ORI:  inst_type = `INST_TYPE_OR;
            `OP_LW:   inst_type = `INST_TYPE_LW;
            `OP_SW:   inst_type = `INST_TYPE_SW;
            `OP_BEQ:  inst_type = `INST_TYPE_BEQ;
            `OP_BNE:  inst_type = `INST_TYPE_BNE;
            `OP_JMP:  inst_type = `INST_TYPE_JMP;
            default:  inst_type = `INST_TYPE_NONE;
        endcase
    end

    // Next-state selection
    always_comb begin
        inst_d   = inst_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        num_d    = num_q;
        type_d   = type_q;
        stall_d  = stall_q;
        bubble_d = bubble_q;

        if (do_hold) begin
            if (stall_q != CNT_MAX) begin
                stall_d = stall_q + 1'b1;
            end
        end else if (do_bubble) begin
            // id_pc4 deliberately keeps its previous value across a bubble
            inst_d  = '0;
            valid_d = 1'b0;
            num_d   = if_inst_pc[NUM_W-1:0];
            type_d  = `INST_TYPE_NONE;
            if (bubble_q != CNT_MAX) begin
                bubble_d = bubble_q + 1'b1;
            end
        end else begin
            inst_d  = if_inst;
            pc4_d   = if_pc4;
            valid_d = 1'b1;
            num_d   = if_inst_pc[NUM_W-1:0];
            type_d  = inst_type;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q   <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            num_q    <= '0;
            type_q   <= `INST_TYPE_NONE;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            inst_q   <= inst_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            num_q    <= num_d;
            type_q   <= type_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign id_inst       = inst_q;
    assign id_pc4        = pc4_q;
    assign id_valid      = valid_q;
    assign ID_ins_number = num_q;
    assign ID_ins_type   = type_q;
    assign stall_cnt     = stall_q;
    assign bubble_cnt    = bubble_q;

endmodule
